countdown_timer_ctrl: RTL and testbench

//  Sequencing FSM for a MM:SS countdown timer. Loads the start time from switches, then counts down
//  on 1 Hz ticks derived from the clock-divider output. Drives the divider's frequency select and

---
 rtl/timer_pkg.sv | 17 +
 rtl/rise_pulse.sv | 21 ++
 rtl/countdown_timer_ctrl.sv | 149 ++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared encodings and defaults for the MM:SS countdown timer.
package timer_pkg;

    localparam int STATE_W     = 3;
    localparam int SEC_MAX_DEF = 59;
    localparam int MIN_MAX_DEF = 99;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_SET_SEC = 3'd1,
        S_SET_MIN = 3'd2,
        S_RUN     = 3'd3,
        S_PAUSE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/rise_pulse.sv
// Turns a level into a one-cycle pulse on its rising edge.
module rise_pulse (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Sequencing FSM for an MM:SS countdown timer driving a clock divider
// and a blinking display on expiry.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int SEC_MAX = SEC_MAX_DEF,
    parameter int MIN_MAX = MIN_MAX_DEF,
    parameter int W       = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key_next,
    input  logic               key_go,
    input  logic [W-1:0]       sw_val,
    input  logic               div_level,
    output logic               div_flash,
    output logic               div_clear,
    output logic [W-1:0]       seconds,
    output logic [W-1:0]       minutes,
    output logic               blank,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [W-1:0] SEC_TOP = W'(SEC_MAX);
    localparam logic [W-1:0] MIN_TOP = W'(MIN_MAX);

    state_t       state;
    logic         tick;
    logic         run_tick;
    logic         time_nz;
    logic         dec_zero;
    logic [W-1:0] sec_dec;
    logic [W-1:0] min_dec;
    logic [W-1:0] sec_clamp;
    logic [W-1:0] min_clamp;

    rise_pulse u_tick (
        .clock (clock),
        .reset (reset),
        .level (div_level),
        .pulse (tick)
    );

    assign state_o   = state;
    assign time_nz   = (seconds != '0) || (minutes != '0);
    assign sec_clamp = (sw_val > SEC_TOP) ? SEC_TOP : sw_val;
    assign min_clamp = (sw_val > MIN_TOP) ? MIN_TOP : sw_val;
    // A tick that lands on an accepted key is dropped.
    assign run_tick  = tick & ~key_next & ~key_go;

    always_comb begin
        sec_dec = seconds;
        min_dec = minutes;
        if (seconds != '0) begin
            sec_dec = seconds - 1'b1;
        end else if (minutes != '0) begin
            min_dec = minutes - 1'b1;
            sec_dec = SEC_TOP;
        end
    end

    assign dec_zero = (sec_dec == '0) && (min_dec == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            div_flash <= 1'b0;
            div_clear <= 1'b1;
            blank     <= 1'b0;
        end else begin
            div_clear <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_next) begin
                        state <= S_SET_SEC;
                    end else if (key_go && time_nz) begin
                        state     <= S_RUN;
                        div_clear <= 1'b1;
                    end
                end
                S_SET_SEC: begin
                    if (key_next) begin
                        state <= S_SET_MIN;
                    end
                end
                S_SET_MIN: begin
                    if (key_next) begin
                        state <= S_IDLE;
                    end else if (key_go && time_nz) begin
                        state     <= S_RUN;
                        div_clear <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (key_next) begin
                        state <= S_IDLE;
                    end else if (key_go) begin
                        state <= S_PAUSE;
                    end else if ((tick && dec_zero) || !time_nz) begin
                        state     <= S_DONE;
                        div_flash <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (key_next) begin
                        state <= S_IDLE;
                    end else if (key_go) begin
                        state     <= S_RUN;
                        div_clear <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (key_next || key_go) begin
                        state     <= S_IDLE;
                        blank     <= 1'b0;
                        div_flash <= 1'b0;
                    end else if (tick) begin
                        blank <= ~blank;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    blank     <= 1'b0;
                    div_flash <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seconds <= '0;
            minutes <= '0;
        end else begin
            case (state)
                S_SET_SEC: seconds <= sec_clamp;
                S_SET_MIN: minutes <= min_clamp;
                S_RUN: begin
                    if (run_tick) begin
                        seconds <= sec_dec;
                        minutes <= min_dec;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with hand-computed expectations.
module tb_countdown_timer_ctrl;

    localparam int W = 7;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         key_next = 1'b0;
    logic         key_go = 1'b0;
    logic [W-1:0] sw_val = '0;
    logic         div_level = 1'b0;
    logic         div_flash;
    logic         div_clear;
    logic [W-1:0] seconds;
    logic [W-1:0] minutes;
    logic         blank;
    logic [2:0]   state_o;

    int checks = 0;
    int errors = 0;

    countdown_timer_ctrl #(.SEC_MAX(59), .MIN_MAX(99), .W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .key_next  (key_next),
        .key_go    (key_go),
        .sw_val    (sw_val),
        .div_level (div_level),
        .div_flash (div_flash),
        .div_clear (div_clear),
        .seconds   (seconds),
        .minutes   (minutes),
        .blank     (blank),
        .state_o   (state_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic press_next();
        key_next = 1'b1;
        cyc();
        key_next = 1'b0;
    endtask

    task automatic press_go();
        key_go = 1'b1;
        cyc();
        key_go = 1'b0;
    endtask

    task automatic tick();
        div_level = 1'b1;
        cyc();
        div_level = 1'b0;
        cyc();
    endtask

    task automatic check_time(input string tag, input int m, input int s);
        check({tag, "_min"}, 32'(minutes), 32'(m));
        check({tag, "_sec"}, 32'(seconds), 32'(s));
    endtask

    task automatic load(input int s, input int m);
        press_next();
        sw_val = W'(s);
        cyc();
        press_next();
        sw_val = W'(m);
        cyc();
    endtask

    initial begin
        // reset state
        reset = 1'b1;
        cyc();
        check("rst_state", 32'(state_o), 0);
        check_time("rst", 0, 0);
        check("rst_flash", 32'(div_flash), 0);
        check("rst_clear", 32'(div_clear), 1);
        check("rst_blank", 32'(blank), 0);
        reset = 1'b0;
        cyc();
        check("rst_clear_drop", 32'(div_clear), 0);

        // 1: load with seconds clamp, start
        press_next();
        check("t1_setsec", 32'(state_o), 1);
        sw_val = 7'd75;
        cyc();
        check("t1_clamp_sec", 32'(seconds), 59);
        press_next();
        check("t1_setmin", 32'(state_o), 2);
        sw_val = 7'd2;
        cyc();
        check("t1_min", 32'(minutes), 2);
        press_go();
        check("t1_run", 32'(state_o), 3);
        check("t1_clear", 32'(div_clear), 1);
        check_time("t1", 2, 59);
        cyc();
        check("t1_clear_1cyc", 32'(div_clear), 0);

        // 2: count down through a minute borrow to expiry
        for (int i = 0; i < 119; i++) tick();
        check_time("t2_at100", 1, 0);
        tick();
        check_time("t2_borrow", 0, 59);
        check("t2_borrow_state", 32'(state_o), 3);
        for (int i = 0; i < 58; i++) tick();
        check_time("t2_at001", 0, 1);
        check("t2_still_run", 32'(state_o), 3);
        div_level = 1'b1;
        cyc();
        check_time("t2_zero", 0, 0);
        check("t2_done", 32'(state_o), 5);
        check("t2_flash", 32'(div_flash), 1);
        div_level = 1'b0;
        cyc();

        // 3: blink in DONE, then exit
        tick();
        check("t3_blank1", 32'(blank), 1);
        tick();
        check("t3_blank2", 32'(blank), 0);
        tick();
        check("t3_blank3", 32'(blank), 1);
        tick();
        check("t3_blank4", 32'(blank), 0);
        tick();
        check("t3_blank5", 32'(blank), 1);
        press_go();
        check("t3_idle", 32'(state_o), 0);
        check("t3_blank_off", 32'(blank), 0);
        check("t3_flash_off", 32'(div_flash), 0);
        press_go();
        check("t3_go_zero_idle", 32'(state_o), 0);

        // 4: pause with coincident tick
        load(5, 1);
        press_go();
        check("t4_run", 32'(state_o), 3);
        tick();
        check_time("t4_first", 1, 4);
        key_go = 1'b1;
        div_level = 1'b1;
        cyc();
        key_go = 1'b0;
        div_level = 1'b0;
        check("t4_pause", 32'(state_o), 4);
        check_time("t4_tick_dropped", 1, 4);
        cyc();
        for (int i = 0; i < 3; i++) tick();
        check_time("t4_frozen", 1, 4);
        check("t4_still_pause", 32'(state_o), 4);
        press_go();
        check("t4_resume", 32'(state_o), 3);
        check("t4_resume_clear", 32'(div_clear), 1);
        tick();
        check_time("t4_after_resume", 1, 3);
        press_next();
        check("t4_cancel", 32'(state_o), 0);
        check_time("t4_kept", 1, 3);
        press_go();
        check("t4_idle_go", 32'(state_o), 3);
        check("t4_idle_go_clear", 32'(div_clear), 1);
        press_next();

        // 5: zero time refuses to start; both keys -> next only
        load(0, 0);
        check_time("t5_zero", 0, 0);
        press_go();
        check("t5_stay", 32'(state_o), 2);
        check("t5_no_clear", 32'(div_clear), 0);
        key_go = 1'b1;
        key_next = 1'b1;
        cyc();
        key_go = 1'b0;
        key_next = 1'b0;
        check("t5_both_idle", 32'(state_o), 0);
        check("t5_both_noclr", 32'(div_clear), 0);

        // 6: reset mid-run
        load(17, 3);
        press_go();
        check("t6_run", 32'(state_o), 3);
        check_time("t6_loaded", 3, 17);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("t6_idle", 32'(state_o), 0);
        check_time("t6_cleared", 0, 0);
        check("t6_flash", 32'(div_flash), 0);
        check("t6_clear", 32'(div_clear), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
